// File: rtl/vga_timing_pkg.sv
// Shared raster constants and helpers for vga_sync_gen.
// The colour-bar table only exists when VGA_TEST_PATTERN_EN is defined.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int CLK_DIV_DEF   = 4;
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int line_total(input int vis, input int fp, input int sw, input int bp);
    return vis + fp + sw + bp;
  endfunction

  localparam int H_TOTAL_DEF = line_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = line_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

`ifdef VGA_TEST_PATTERN_EN
  localparam int N_BARS = 8;

  // {R,G,B} with each channel bit duplicated: black .. white
  localparam logic [5:0] BAR_RGB [N_BARS] = '{
    6'b000000, 6'b000011, 6'b001100, 6'b001111,
    6'b110000, 6'b110011, 6'b111100, 6'b111111
  };

  function automatic logic [5:0] bar_colour(input logic [2:0] k);
    return BAR_RGB[k];
  endfunction
`endif

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster output bundle of vga_sync_gen; RGB is present only with VGA_TEST_PATTERN_EN.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             HSYNC;
  logic             VSYNC;
  logic             Blank;
  logic [CNT_W-1:0] PIXEL_X;
  logic [CNT_W-1:0] PIXEL_Y;
  logic             PIXEL_TICK;
  logic             FRAME_START;
`ifdef VGA_TEST_PATTERN_EN
  logic [5:0]       RGB;
`endif

  modport master (
    output HSYNC, VSYNC, Blank, PIXEL_X, PIXEL_Y, PIXEL_TICK, FRAME_START
`ifdef VGA_TEST_PATTERN_EN
    , output RGB
`endif
  );

  modport slave (
    input HSYNC, VSYNC, Blank, PIXEL_X, PIXEL_Y, PIXEL_TICK, FRAME_START
`ifdef VGA_TEST_PATTERN_EN
    , input RGB
`endif
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Pixel-rate prescaler: counts 0..CLK_DIV-1 and flags the last CLK of each pixel.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  output logic TICK
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] presc_p0;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_p0 <= '0;
    end else if (presc_p0 == LAST) begin
      presc_p0 <= '0;
    end else begin
      presc_p0 <= presc_p0 + 1'b1;
    end
  end

  assign TICK = (presc_p0 == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: HSYNC/VSYNC/Blank/pixel coordinates from CLK.
// Optional colour-bar output RGB when VGA_TEST_PATTERN_EN is defined.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0
) (
  input  logic           CLK,
  input  logic           RST_N,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = line_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = line_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             tick_p0;
  logic [CNT_W-1:0] h_cnt_p0;
  logic [CNT_W-1:0] v_cnt_p0;

  logic             blank_d;
  logic             hs_act_d;
  logic             vs_act_d;
  logic             wrap_d;

  logic             hsync_p1;
  logic             vsync_p1;
  logic             blank_p1;
  logic             tick_p1;
  logic             wrap_p1;
  logic [CNT_W-1:0] x_p1;
  logic [CNT_W-1:0] y_p1;
  logic             fstart_p2;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .CLK   (CLK),
    .RST_N (RST_N),
    .TICK  (tick_p0)
  );

  // ---- stage p0: raster counters, advance once per pixel ----
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
    end else if (tick_p0) begin
      if (h_cnt_p0 == H_LAST) begin
        h_cnt_p0 <= '0;
        if (v_cnt_p0 == V_LAST) begin
          v_cnt_p0 <= '0;
        end else begin
          v_cnt_p0 <= v_cnt_p0 + 1'b1;
        end
      end else begin
        h_cnt_p0 <= h_cnt_p0 + 1'b1;
      end
    end
  end

  always_comb begin
    blank_d  = (h_cnt_p0 >= H_VIS_C) | (v_cnt_p0 >= V_VIS_C);
    hs_act_d = (h_cnt_p0 >= HS_BEG) & (h_cnt_p0 < HS_END);
    vs_act_d = (v_cnt_p0 >= VS_BEG) & (v_cnt_p0 < VS_END);
    wrap_d   = tick_p0 & (h_cnt_p0 == H_LAST) & (v_cnt_p0 == V_LAST);
  end

  // ---- stage p1: registered outputs, decoded from the p0 counters ----
  // wrap_p1 marks the last CLK of (H_TOTAL-1, V_TOTAL-1); delaying it once more
  // lands FRAME_START on the first CLK in which PIXEL_X/PIXEL_Y read (0,0).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_p1      <= '0;
      y_p1      <= '0;
      blank_p1  <= 1'b1;
      hsync_p1  <= ~HS_POL;
      vsync_p1  <= ~VS_POL;
      tick_p1   <= 1'b0;
      wrap_p1   <= 1'b0;
      fstart_p2 <= 1'b0;
    end else begin
      x_p1      <= h_cnt_p0;
      y_p1      <= v_cnt_p0;
      blank_p1  <= blank_d;
      hsync_p1  <= hs_act_d ? HS_POL : ~HS_POL;
      vsync_p1  <= vs_act_d ? VS_POL : ~VS_POL;
      tick_p1   <= tick_p0;
      wrap_p1   <= wrap_d;
      fstart_p2 <= wrap_p1;
    end
  end

  assign vga.HSYNC       = hsync_p1;
  assign vga.VSYNC       = vsync_p1;
  assign vga.Blank       = blank_p1;
  assign vga.PIXEL_X     = x_p1;
  assign vga.PIXEL_Y     = y_p1;
  assign vga.PIXEL_TICK  = tick_p1;
  assign vga.FRAME_START = fstart_p2;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_VISIBLE / N_BARS);

  logic [2:0] bar_k_d;
  logic [5:0] rgb_p1;

  always_comb begin
    bar_k_d = 3'(h_cnt_p0 / BAR_W);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rgb_p1 <= '0;
    end else begin
      rgb_p1 <= blank_d ? 6'b000000 : bar_colour(bar_k_d);
    end
  end

  assign vga.RGB = rgb_p1;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a reduced raster (24x15 pixels, CLK_DIV=4) so whole
// frames fit in a short run; an arithmetic raster model is checked every CLK.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int D   = 4;
  localparam int HV  = 16;
  localparam int HF  = 2;
  localparam int HSW = 3;
  localparam int HB  = 3;
  localparam int VV  = 8;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int HT  = HV + HF + HSW + HB;
  localparam int VT  = VV + VF + VSW + VB;
  localparam int FRAME_PIX = HT * VT;

  logic CLK;
  logic RST_N;
  vga_sync_gen_if vif ();

  vga_sync_gen #(
    .CLK_DIV(D), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .vga   (vif)
  );

  int nvec = 0;
  int nerr = 0;
  int m    = 0;
  bit chk_en = 0;
  logic [CNT_W-1:0] last_x, last_y;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: m = number of non-reset CLK edges since the last reset edge.
  always @(posedge CLK) begin
    if (!RST_N) m <= 0;
    else        m <= m + 1;
  end

  always @(negedge CLK) begin : cmp
    int n, p, ex, ey;
    logic etick, eblank, ehs, evs, efs;
    if (chk_en) begin
      if (m == 0) begin
        ex = 0; ey = 0; etick = 0; eblank = 1; ehs = 1; evs = 1; efs = 0;
      end else begin
        n      = m - 1;
        p      = (n / D) % FRAME_PIX;
        ex     = p % HT;
        ey     = p / HT;
        etick  = ((n % D) == D - 1);
        eblank = (ex >= HV) || (ey >= VV);
        ehs    = (ex >= HV + HF && ex < HV + HF + HSW) ? 1'b0 : 1'b1;
        evs    = (ey >= VV + VF && ey < VV + VF + VSW) ? 1'b0 : 1'b1;
        efs    = (m >= 2) && ((n % D) == 0) && (p == 0);
      end
      chk("PIXEL_X",     32'(vif.PIXEL_X),     32'(ex));
      chk("PIXEL_Y",     32'(vif.PIXEL_Y),     32'(ey));
      chk("PIXEL_TICK",  32'(vif.PIXEL_TICK),  32'(etick));
      chk("Blank",       32'(vif.Blank),       32'(eblank));
      chk("HSYNC",       32'(vif.HSYNC),       32'(ehs));
      chk("VSYNC",       32'(vif.VSYNC),       32'(evs));
      chk("FRAME_START", 32'(vif.FRAME_START), 32'(efs));
`ifdef VGA_TEST_PATTERN_EN
      begin
        logic [2:0] kk;
        logic [5:0] erg;
        kk  = 3'(ex / (HV / 8));
        erg = eblank ? 6'b0 : {kk[2], kk[2], kk[1], kk[1], kk[0], kk[0]};
        chk("RGB", 32'(vif.RGB), 32'(erg));
      end
`endif
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return vif.HSYNC;
      1:       return vif.VSYNC;
      2:       return vif.FRAME_START;
      3:       return vif.PIXEL_TICK;
      4:       return (vif.PIXEL_Y == 10'd5);
      default: return (vif.PIXEL_X == 10'd15) && (vif.Blank == 1'b0);
    endcase
  endfunction

  // Steps CLK until the selected signal reads val (#1 after the edge); n = edges taken.
  task automatic wait_for(input int sel, input logic val, input int bound, output int n);
    n = 0;
    do begin
      last_x = vif.PIXEL_X;
      last_y = vif.PIXEL_Y;
      @(posedge CLK);
      #1;
      n++;
    end while (sig(sel) !== val && n < bound);
    if (sig(sel) !== val) begin
      nvec++;
      nerr++;
      $display("FAIL wait sel=%0d: not %b within %0d CLK", sel, val, bound);
    end
  endtask

  initial begin
    int n, n2;
    $display("info: default frame would be %0d CLK", H_TOTAL_DEF * V_TOTAL_DEF * CLK_DIV_DEF);
    RST_N = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk_en = 1;
    chk("rst Blank", 32'(vif.Blank), 1);
    chk("rst HSYNC", 32'(vif.HSYNC), 1);
    chk("rst VSYNC", 32'(vif.VSYNC), 1);
    chk("rst PIXEL_X", 32'(vif.PIXEL_X), 0);
    chk("rst PIXEL_Y", 32'(vif.PIXEL_Y), 0);
    chk("rst PIXEL_TICK", 32'(vif.PIXEL_TICK), 0);
    RST_N = 1'b1;

    wait_for(3, 1'b1, 20, n);
    chk("first tick latency", 32'(n), 4);

    // line timing: sync starts at x=HV+HF, lasts HSW pixels, repeats every HT pixels
    wait_for(0, 1'b1, 200, n);
    wait_for(0, 1'b0, 200, n);
    chk("hsync fall x", 32'(vif.PIXEL_X), 18);
    chk("hsync fall prev x", 32'(last_x), 17);
    chk("hsync fall blank", 32'(vif.Blank), 1);
    wait_for(0, 1'b1, 200, n);
    chk("hsync low width", 32'(n), 12);
    wait_for(0, 1'b0, 200, n2);
    chk("line period", 32'(n + n2), 96);

    // frame timing
    wait_for(1, 1'b0, 2000, n);
    chk("vsync fall y", 32'(vif.PIXEL_Y), 10);
    chk("vsync fall x", 32'(vif.PIXEL_X), 0);
    wait_for(1, 1'b1, 1000, n);
    chk("vsync low width", 32'(n), 192);

    // wrap corner (23,14) -> (0,0)
    wait_for(2, 1'b1, 2000, n);
    chk("fs x", 32'(vif.PIXEL_X), 0);
    chk("fs y", 32'(vif.PIXEL_Y), 0);
    chk("fs blank", 32'(vif.Blank), 0);
    chk("pre-wrap x", 32'(last_x), 23);
    chk("pre-wrap y", 32'(last_y), 14);
    wait_for(2, 1'b0, 10, n);
    chk("fs width", 32'(n), 1);
    wait_for(2, 1'b1, 2000, n2);
    chk("frame period", 32'(n + n2), 1440);

    // mid-frame reset while HSYNC is active
    wait_for(4, 1'b1, 2000, n);
    wait_for(0, 1'b0, 200, n);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("midrst HSYNC", 32'(vif.HSYNC), 1);
    chk("midrst x", 32'(vif.PIXEL_X), 0);
    chk("midrst y", 32'(vif.PIXEL_Y), 0);
    chk("midrst blank", 32'(vif.Blank), 1);
    RST_N = 1'b1;
    wait_for(2, 1'b1, 2000, n);
    chk("frame after reset", 32'(n), 1441);

`ifdef VGA_TEST_PATTERN_EN
    wait_for(5, 1'b1, 2000, n);
    chk("rgb last bar", 32'(vif.RGB), 32'(6'b111111));
`endif

    repeat (3) @(posedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
